// File: rtl/mux_scan_n_1_v_pkg.sv
// Shared constants for the N:1 scanning mux: mode codes and handshake FSM encodings.
package mux_pkg_v;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_VALID = 2'b01,
    ST_STALL = 2'b10
  } state_t;

endpackage

// File: rtl/mux_scan_n_1_v_ptr.sv
// Wrap-around scan pointer over 0..N_CH-1 with a same-cycle restart to channel 0.
// Latency: o_ptr/o_last are combinational from the registered pointer and i_load0.
// Backpressure: holds while i_adv is low, so a stalled output freezes the scan.
module mux_scan_ptr_v #(
  parameter  int N_CH  = 8,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load0,
  input  logic             i_adv,
  output logic [SEL_W-1:0] o_ptr,
  output logic             o_last
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_CH - 1);

  logic [SEL_W-1:0] ptr_q;

  // A restart takes effect in the same cycle, so the capture it accompanies sees channel 0.
  assign o_ptr  = i_load0 ? '0 : ptr_q;
  assign o_last = (o_ptr == LAST);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ptr_q <= '0;
    end else if (i_adv) begin
      ptr_q <= o_last ? '0 : o_ptr + SEL_W'(1);
    end else if (i_load0) begin
      ptr_q <= '0;
    end
  end

endmodule

// File: rtl/mux_scan_n_1_v.sv
// Registered N:1 mux of W-bit lanes, manual select or auto-scan, valid/ready output.
// Latency: 1 clock from input to o_f; full throughput of one sample per clock.
// Backpressure: o_valid & ~i_ready holds o_f/o_sel/o_valid and freezes the scan pointer.
module mux_scan_n_1_v
  import mux_pkg_v::*;
#(
  parameter  int N_CH  = 8,
  parameter  int W     = 1,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_mode,
  input  logic [N_CH*W-1:0] i_code,
  input  logic [SEL_W-1:0]  i_sel_code,
  input  logic              i_ready,
  output logic [W-1:0]      o_f,
  output logic [SEL_W-1:0]  o_sel,
  output logic              o_valid,
  output logic              o_wrap
);

  state_t           state_q, state_d;
  logic             mode_q;
  logic             mode_scan;
  logic             load0;
  logic             cap;
  logic             adv;
  logic             last;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] src;
  logic [W-1:0]     sel_dat;

  assign mode_scan = (i_mode == MODE_SCAN);
  assign load0     = mode_scan & (mode_q == MODE_MANUAL);
  assign o_valid   = (state_q != ST_IDLE);
  assign cap       = i_en & (~o_valid | i_ready);
  assign adv       = cap & mode_scan;
  assign src       = mode_scan ? ptr : i_sel_code;

  mux_scan_ptr_v #(.N_CH(N_CH)) u_ptr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load0 (load0),
    .i_adv   (adv),
    .o_ptr   (ptr),
    .o_last  (last)
  );

  // Codes with no matching lane (non-power-of-2 N_CH) fall through to zero.
  always_comb begin
    sel_dat = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (src == SEL_W'(k)) sel_dat = i_code[k*W +: W];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cap) state_d = ST_VALID;
      end
      ST_VALID: begin
        if (cap)           state_d = ST_VALID;
        else if (!i_ready) state_d = ST_STALL;
        else               state_d = ST_IDLE;
      end
      ST_STALL: begin
        if (i_ready) state_d = i_en ? ST_VALID : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_MANUAL;
      o_f     <= '0;
      o_sel   <= '0;
      o_wrap  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= i_mode;
      o_wrap  <= adv & last;
      if (cap) begin
        o_f   <= sel_dat;
        o_sel <= src;
      end else if (!i_en && (!o_valid || i_ready)) begin
        // Drain clears data but keeps o_sel as a record of the last channel.
        o_f <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mux_scan_n_1_v.sv
// Directed bench: three instances (8x1, 8x4, 5x4) share control inputs and are checked per phase.
module tb_mux_scan_n_1_v;

  logic        clk = 1'b0;
  logic        rst_n, en, mode, ready;
  logic [2:0]  sel;
  logic [7:0]  code_a;
  logic [31:0] code_b;
  logic [19:0] code_c;

  logic        f_a;
  logic [3:0]  f_b, f_c;
  logic [2:0]  sel_a, sel_b, sel_c;
  logic        vld_a, vld_b, vld_c;
  logic        wrap_a, wrap_b, wrap_c;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  mux_scan_n_1_v #(.N_CH(8), .W(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_mode(mode), .i_code(code_a),
    .i_sel_code(sel), .i_ready(ready), .o_f(f_a), .o_sel(sel_a), .o_valid(vld_a), .o_wrap(wrap_a));

  mux_scan_n_1_v #(.N_CH(8), .W(4)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_mode(mode), .i_code(code_b),
    .i_sel_code(sel), .i_ready(ready), .o_f(f_b), .o_sel(sel_b), .o_valid(vld_b), .o_wrap(wrap_b));

  mux_scan_n_1_v #(.N_CH(5), .W(4)) dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_mode(mode), .i_code(code_c),
    .i_sel_code(sel), .i_ready(ready), .o_f(f_c), .o_sel(sel_c), .o_valid(vld_c), .o_wrap(wrap_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic [3:0] f, input logic [2:0] s,
                       input logic v, input logic w);
    chk({tag, ".f"},    32'(f_b),    32'(f));
    chk({tag, ".sel"},  32'(sel_b),  32'(s));
    chk({tag, ".vld"},  32'(vld_b),  32'(v));
    chk({tag, ".wrap"}, 32'(wrap_b), 32'(w));
  endtask

  initial begin
    rst_n  = 1'b0;
    en     = 1'b0;
    mode   = 1'b0;
    ready  = 1'b1;
    sel    = 3'd2;
    code_a = 8'b1010_0101;
    code_b = 32'h8765_4321;
    code_c = 20'h5_4321;

    tick();
    tick();
    chk("rst.a.f",    32'(f_a),    32'd0);
    chk("rst.a.sel",  32'(sel_a),  32'd0);
    chk("rst.a.vld",  32'(vld_a),  32'd0);
    chk("rst.a.wrap", 32'(wrap_a), 32'd0);
    chk_b("rst.b", 4'd0, 3'd0, 1'b0, 1'b0);
    chk("rst.c.vld",  32'(vld_c),  32'd0);

    // Manual select
    rst_n = 1'b1;
    en    = 1'b1;
    tick();
    chk("man2.a.f",   32'(f_a),   32'd1);
    chk("man2.a.sel", 32'(sel_a), 32'd2);
    chk("man2.a.vld", 32'(vld_a), 32'd1);
    chk_b("man2.b", 4'd3, 3'd2, 1'b1, 1'b0);

    sel = 3'd3;
    tick();
    chk("man3.a.f",   32'(f_a),   32'd0);
    chk("man3.a.sel", 32'(sel_a), 32'd3);
    chk("man3.b.f",   32'(f_b),   32'd4);

    // Out-of-range select on the 5-lane instance
    sel = 3'd6;
    tick();
    chk("oor.c.f",   32'(f_c),   32'd0);
    chk("oor.c.sel", 32'(sel_c), 32'd6);
    chk("oor.c.vld", 32'(vld_c), 32'd1);
    chk("oor.a.f",   32'(f_a),   32'd0);
    chk("oor.b.f",   32'(f_b),   32'd7);

    sel = 3'd4;
    tick();
    chk("man4.c.f", 32'(f_c), 32'd5);

    // Auto-scan: first capture is channel 0, then wraps per instance size
    mode = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      tick();
      chk_b($sformatf("scan%0d.b", i), 4'((i % 8) + 1), 3'(i % 8), 1'b1, (i % 8) == 7);
      chk($sformatf("scan%0d.c.f", i),    32'(f_c),    32'((i % 5) + 1));
      chk($sformatf("scan%0d.c.wrap", i), 32'(wrap_c), 32'((i % 5) == 4));
    end

    // Stall while o_f=3; input changes must be ignored
    ready  = 1'b0;
    code_b = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_b($sformatf("stall%0d.b", i), 4'd3, 3'd2, 1'b1, 1'b0);
    end
    code_b = 32'h8765_4321;
    ready  = 1'b1;
    tick();
    chk_b("unstall.b", 4'd4, 3'd3, 1'b1, 1'b0);

    // Drain with ready high
    en = 1'b0;
    tick();
    chk_b("drain.b", 4'd0, 3'd3, 1'b0, 1'b0);

    // Drain requested during a stall waits for ready
    en = 1'b1;
    tick();
    chk_b("cap5.b", 4'd5, 3'd4, 1'b1, 1'b0);
    ready = 1'b0;
    en    = 1'b0;
    tick();
    chk_b("sdrain0.b", 4'd5, 3'd4, 1'b1, 1'b0);
    tick();
    chk_b("sdrain1.b", 4'd5, 3'd4, 1'b1, 1'b0);
    ready = 1'b1;
    tick();
    chk_b("sdrain2.b", 4'd0, 3'd4, 1'b0, 1'b0);

    // Scan resumes where it stopped, then manual and a 0->1 restart
    en = 1'b1;
    tick();
    chk_b("resume.b", 4'd6, 3'd5, 1'b1, 1'b0);
    mode = 1'b0;
    sel  = 3'd7;
    tick();
    chk_b("man7.b", 4'd8, 3'd7, 1'b1, 1'b0);
    mode = 1'b1;
    tick();
    chk_b("restart.b", 4'd1, 3'd0, 1'b1, 1'b0);
    tick();
    chk_b("restart1.b", 4'd2, 3'd1, 1'b1, 1'b0);

    // Reset during a stall drops the held sample
    ready = 1'b0;
    tick();
    chk_b("prerst.b", 4'd2, 3'd1, 1'b1, 1'b0);
    rst_n = 1'b0;
    tick();
    chk_b("midrst.b", 4'd0, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    ready = 1'b1;
    tick();
    chk_b("postrst.b", 4'd1, 3'd0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
